// File: rtl/mips_pkg.sv
// Shared constants for the multicycle MIPS control path: opcodes, functs,
// ALU control codes, mux select codes and FSM state encodings.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_RT      = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11,
    S_TRAP     = 4'd12
  } state_t;

endpackage

// File: rtl/mips_alu_decoder.sv
// R-type funct decode: ALU operation plus a flag for functs the core does not implement.
module mips_alu_decoder
  import mips_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alu_control,
  output logic       funct_illegal
);

  always_comb begin
    alu_control   = ALU_ADD;
    funct_illegal = 1'b0;
    case (funct)
      FN_ADD:  alu_control = ALU_ADD;
      FN_SUB:  alu_control = ALU_SUB;
      FN_AND:  alu_control = ALU_AND;
      FN_OR:   alu_control = ALU_OR;
      FN_SLT:  alu_control = ALU_SLT;
      default: funct_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control FSM: sequences the shared memory and ALU per instruction,
// with memory wait states, optional bne and an illegal-instruction trap.
module mips_multicycle_control
  import mips_pkg::*;
#(
  parameter bit USE_MEM_READY = 1'b1,
  parameter bit SUPPORT_BNE   = 1'b1,
  parameter int STATE_W       = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_en,
  output logic               iord,
  output logic               mem_write,
  output logic               ir_write,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [2:0]         alu_control,
  output logic [1:0]         pc_src,
  output logic               illegal_instr,
  output logic [STATE_W-1:0] state_dbg
);

  state_t     state_q;
  logic [3:0] state_bits;
  logic       mem_rdy;
  logic       take;
  logic [2:0] dec_alu_control;
  logic       dec_funct_illegal;

  assign mem_rdy    = USE_MEM_READY ? mem_ready : 1'b1;
  assign take       = (opcode == OP_BNE) ? ~zero : zero;
  assign state_bits = state_q;
  assign state_dbg  = STATE_W'(state_bits);

  mips_alu_decoder u_alu_decoder (
    .funct         (funct),
    .alu_control   (dec_alu_control),
    .funct_illegal (dec_funct_illegal)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_FETCH;
    end else begin
      case (state_q)
        S_FETCH:    if (mem_rdy) state_q <= S_DECODE;
        S_DECODE: begin
          case (opcode)
            OP_LW, OP_SW: state_q <= S_MEMADR;
            OP_RTYPE:     state_q <= S_EXECUTE;
            OP_BEQ:       state_q <= S_BRANCH;
            OP_BNE:       state_q <= SUPPORT_BNE ? S_BRANCH : S_TRAP;
            OP_ADDI:      state_q <= S_ADDIEXEC;
            OP_J:         state_q <= S_JUMP;
            default:      state_q <= S_TRAP;
          endcase
        end
        S_MEMADR:   state_q <= (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
        S_MEMREAD:  if (mem_rdy) state_q <= S_MEMWB;
        S_MEMWRITE: if (mem_rdy) state_q <= S_FETCH;
        S_EXECUTE:  state_q <= dec_funct_illegal ? S_TRAP : S_ALUWB;
        S_ADDIEXEC: state_q <= S_ADDIWB;
        S_TRAP:     state_q <= S_TRAP;
        // MEMWB, ALUWB, BRANCH, ADDIWB, JUMP and the unused codes all return to fetch.
        default:    state_q <= S_FETCH;
      endcase
    end
  end

  // Outputs are forced low while reset_n is low so no write enable leaks during reset.
  always_comb begin
    pc_en         = 1'b0;
    iord          = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_RT;
    alu_control   = 3'b000;
    pc_src        = PCSRC_ALU;
    illegal_instr = 1'b0;
    if (reset_n) begin
      case (state_q)
        S_FETCH: begin
          alu_src_b   = SRCB_FOUR;
          alu_control = ALU_ADD;
          ir_write    = mem_rdy;
          pc_en       = mem_rdy;
        end
        S_DECODE: begin
          alu_src_b   = SRCB_IMM_SH2;
          alu_control = ALU_ADD;
        end
        S_MEMADR, S_ADDIEXEC: begin
          alu_src_a   = 1'b1;
          alu_src_b   = SRCB_IMM;
          alu_control = ALU_ADD;
        end
        S_MEMREAD:  iord = 1'b1;
        S_MEMWB: begin
          mem_to_reg = 1'b1;
          reg_write  = 1'b1;
        end
        S_MEMWRITE: begin
          iord      = 1'b1;
          mem_write = 1'b1;
        end
        S_EXECUTE: begin
          alu_src_a   = 1'b1;
          alu_control = dec_alu_control;
        end
        S_ALUWB: begin
          reg_dst   = 1'b1;
          reg_write = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a   = 1'b1;
          alu_control = ALU_SUB;
          pc_src      = PCSRC_ALUOUT;
          pc_en       = take;
        end
        S_ADDIWB:   reg_write = 1'b1;
        S_JUMP: begin
          pc_src = PCSRC_JUMP;
          pc_en  = 1'b1;
        end
        S_TRAP:     illegal_instr = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Randomized bench for mips_multicycle_control: an instruction-level model expands each
// instruction into its expected per-cycle control vector, compared cycle by cycle.
module tb_mips_multicycle_control;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [5:0] opcode = '0;
  logic [5:0] funct = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;

  logic       pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
  logic [1:0] alu_src_b, pc_src;
  logic [2:0] alu_control;
  logic       illegal_instr;
  logic [3:0] state_dbg;

  logic       nb_pc_en, nb_iord, nb_mem_write, nb_ir_write, nb_reg_dst, nb_mem_to_reg;
  logic       nb_reg_write, nb_alu_src_a, nb_illegal_instr;
  logic [1:0] nb_alu_src_b, nb_pc_src;
  logic [2:0] nb_alu_control;
  logic [3:0] nb_state_dbg;

  logic [19:0] obs;
  assign obs = {pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a,
                alu_src_b, alu_control, pc_src, illegal_instr, state_dbg};

  mips_multicycle_control dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_en(pc_en), .iord(iord), .mem_write(mem_write),
    .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_control(alu_control),
    .pc_src(pc_src), .illegal_instr(illegal_instr), .state_dbg(state_dbg)
  );

  mips_multicycle_control #(.SUPPORT_BNE(1'b0)) dut_nobne (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_en(nb_pc_en), .iord(nb_iord), .mem_write(nb_mem_write),
    .ir_write(nb_ir_write), .reg_dst(nb_reg_dst), .mem_to_reg(nb_mem_to_reg),
    .reg_write(nb_reg_write), .alu_src_a(nb_alu_src_a), .alu_src_b(nb_alu_src_b),
    .alu_control(nb_alu_control), .pc_src(nb_pc_src), .illegal_instr(nb_illegal_instr),
    .state_dbg(nb_state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [19:0] exp_q[$];
  logic [19:0] mask_q[$];
  logic        rdy_q[$];
  string       tag_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Pack one expected cycle in the same field order as obs.
  function automatic logic [19:0] pk(input int st, input bit pe, input bit io, input bit mw,
                                     input bit irw, input bit rd, input bit m2r, input bit rw,
                                     input bit sa, input logic [1:0] sb, input logic [2:0] ac,
                                     input logic [1:0] ps, input bit ill);
    return {pe, io, mw, irw, rd, m2r, rw, sa, sb, ac, ps, ill, 4'(st)};
  endfunction

  // Returns {legal, alu code} for an R-type funct.
  function automatic logic [3:0] alu_of(input logic [5:0] fn);
    case (fn)
      6'b100000: return 4'b1_010;
      6'b100010: return 4'b1_110;
      6'b100100: return 4'b1_000;
      6'b100101: return 4'b1_001;
      6'b101010: return 4'b1_111;
      default:   return 4'b0_000;
    endcase
  endfunction

  task automatic push(input string tag, input logic [19:0] e, input bit rdy,
                      input logic [19:0] m = 20'hFFFFF);
    tag_q.push_back(tag);
    exp_q.push_back(e);
    rdy_q.push_back(rdy);
    mask_q.push_back(m);
  endtask

  function automatic bit rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  // Instruction-level reference: expands one instruction into its cycle sequence.
  task automatic model_instr(input logic [5:0] op, input logic [5:0] fn, input bit z,
                             input int fstall, input int mstall, input int hold,
                             output bit trapped);
    logic [3:0] a;
    trapped = 1'b0;
    for (int i = 0; i < fstall; i++)
      push("fetch_wait", pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 3'b010, 2'b00, 0), 1'b0);
    push("fetch", pk(0, 1, 0, 0, 1, 0, 0, 0, 0, 2'b01, 3'b010, 2'b00, 0), 1'b1);
    push("decode", pk(1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 3'b010, 2'b00, 0), rnd());
    case (op)
      6'b100011: begin
        push("lw_memadr", pk(2, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 3'b010, 2'b00, 0), rnd());
        for (int i = 0; i < mstall; i++)
          push("memread_wait", pk(3, 0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 2'b00, 0), 1'b0);
        push("memread", pk(3, 0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 2'b00, 0), 1'b1);
        push("memwb", pk(4, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 3'b000, 2'b00, 0), rnd());
      end
      6'b101011: begin
        push("sw_memadr", pk(2, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 3'b010, 2'b00, 0), rnd());
        for (int i = 0; i < mstall; i++)
          push("memwrite_wait", pk(5, 0, 1, 1, 0, 0, 0, 0, 0, 2'b00, 3'b000, 2'b00, 0), 1'b0);
        push("memwrite", pk(5, 0, 1, 1, 0, 0, 0, 0, 0, 2'b00, 3'b000, 2'b00, 0), 1'b1);
      end
      6'b000000: begin
        a = alu_of(fn);
        if (a[3]) begin
          push("execute", pk(6, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, a[2:0], 2'b00, 0), rnd());
          push("aluwb", pk(7, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 3'b000, 2'b00, 0), rnd());
        end else begin
          // ALU code for an unimplemented funct is unspecified, so it is masked.
          push("execute_bad", pk(6, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b000, 2'b00, 0), rnd(),
               ~20'h00380);
          trapped = 1'b1;
        end
      end
      6'b000100:
        push("beq", pk(8, z, 0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b110, 2'b01, 0), rnd());
      6'b000101:
        push("bne", pk(8, !z, 0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b110, 2'b01, 0), rnd());
      6'b001000: begin
        push("addiexec", pk(9, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 3'b010, 2'b00, 0), rnd());
        push("addiwb", pk(10, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 3'b000, 2'b00, 0), rnd());
      end
      6'b000010:
        push("jump", pk(11, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 2'b10, 0), rnd());
      default: trapped = 1'b1;
    endcase
    if (trapped)
      for (int i = 0; i < hold; i++)
        push("trap", pk(12, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 2'b00, 1), rnd());
  endtask

  // ---------------- driver ----------------
  task automatic drain(input int keep);
    logic [19:0] e, m;
    while (exp_q.size() > keep) begin
      @(negedge clk);
      mem_ready = rdy_q.pop_front();
      #1;
      e = exp_q.pop_front();
      m = mask_q.pop_front();
      check(tag_q.pop_front(), 32'(obs & m), 32'(e & m));
    end
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    reset_n   = 1'b0;
    mem_ready = rnd();
    #1 check("reset_outputs", 32'(obs), 32'h0);
    @(negedge clk);
    reset_n   = 1'b1;
    mem_ready = 1'b0;
    #1 check("post_reset_fetch", 32'(obs),
             32'(pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 3'b010, 2'b00, 0)));
  endtask

  task automatic run(input logic [5:0] op, input logic [5:0] fn, input bit z,
                     input int fstall, input int mstall, input int hold, input int keep,
                     output bit trapped);
    opcode = op;
    funct  = fn;
    zero   = z;
    model_instr(op, fn, z, fstall, mstall, hold, trapped);
    drain(keep);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit          tr;
    logic [5:0]  op, fn;
    logic [19:0] e;
    int          kind;
    logic [5:0]  legal_fn[5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

    reset_pulse();

    run(6'b100011, 6'b0, 1'b0, 0, 0, 0, 0, tr);           // lw, no stalls: 5 cycles
    run(6'b000000, 6'b100000, 1'b0, 0, 0, 0, 0, tr);      // add
    run(6'b000000, 6'b100010, 1'b0, 0, 0, 0, 0, tr);      // sub
    run(6'b000100, 6'b0, 1'b1, 0, 0, 0, 0, tr);           // beq taken
    run(6'b000100, 6'b0, 1'b0, 0, 0, 0, 0, tr);           // beq not taken
    check("nobne_idle", 32'(nb_illegal_instr), 32'h0);
    run(6'b000101, 6'b0, 1'b0, 0, 0, 0, 0, tr);           // bne taken
    check("nobne_trap", 32'({nb_illegal_instr, nb_state_dbg}), 32'h1C);
    reset_pulse();
    run(6'b000101, 6'b0, 1'b1, 0, 0, 0, 0, tr);           // bne not taken
    run(6'b101011, 6'b0, 1'b0, 2, 3, 0, 0, tr);           // sw, fetch and write stalls
    run(6'b001000, 6'b0, 1'b0, 0, 0, 0, 0, tr);           // addi
    run(6'b000010, 6'b0, 1'b0, 0, 0, 0, 0, tr);           // j
    run(6'b111111, 6'b0, 1'b0, 0, 0, 10, 0, tr);          // illegal opcode
    reset_pulse();
    run(6'b000000, 6'b000111, 1'b0, 0, 0, 10, 0, tr);     // illegal funct
    reset_pulse();

    // Reset asserted in the middle of MEMWB.
    run(6'b100011, 6'b0, 1'b0, 1, 1, 0, 1, tr);
    @(negedge clk);
    mem_ready = rdy_q.pop_front();
    #1;
    e = exp_q.pop_front();
    void'(mask_q.pop_front());
    check(tag_q.pop_front(), 32'(obs), 32'(e));
    #2 reset_n = 1'b0;
    #1 check("reset_mid_memwb", 32'(obs), 32'h0);
    @(negedge clk);
    reset_n   = 1'b1;
    mem_ready = 1'b0;
    #1 check("after_mid_reset_state", 32'(state_dbg), 32'h0);

    // Randomized instruction stream.
    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 8);
      fn   = 6'($urandom);
      case (kind)
        0: op = 6'b100011;
        1: op = 6'b101011;
        2: begin op = 6'b000000; fn = legal_fn[$urandom_range(0, 4)]; end
        3: begin
          op = 6'b000000;
          while (alu_of(fn) != 4'b0000) fn = 6'($urandom);
        end
        4: op = 6'b000100;
        5: op = 6'b000101;
        6: op = 6'b001000;
        7: op = 6'b000010;
        default: begin
          op = 6'($urandom);
          while (op inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000101,
                            6'b001000, 6'b000010})
            op = 6'($urandom);
        end
      endcase
      run(op, fn, rnd(), $urandom_range(0, 2), $urandom_range(0, 2), 3, 0, tr);
      if (tr) reset_pulse();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_control.md
Name: mips_multicycle_control

Overview:
- Control FSM for the multicycle MIPS core; successor to the single-cycle combinational control/top.
- Sequences one shared memory and ALU over several cycles per instruction.
- Adds a memory wait-state handshake, optional bne, and an illegal-instruction trap that the single-cycle design lacks.
- Sits between the instruction register (Opcode/Funct) and the multicycle datapath/unified memory.

Parameters:
- USE_MEM_READY, 1, 1: memory states wait for mem_ready; 0: mem_ready ignored and treated as 1.
- SUPPORT_BNE, 1, 1: opcode 000101 decoded as bne; 0: treated as illegal.
- STATE_W, 4, width of state register and state_dbg output.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- opcode  in  6  IR[31:26].
- funct  in  6  IR[5:0].
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory access completes this cycle.
- pc_en  out  1  PC load enable = pc_write | (branch & take).
- iord  out  1  0: memory address = PC; 1: memory address = ALUOut.
- mem_write  out  1  memory write strobe.
- ir_write  out  1  IR load enable.
- reg_dst  out  1  1: rd; 0: rt.
- mem_to_reg  out  1  1: MDR; 0: ALUOut.
- reg_write  out  1  register file write enable.
- alu_src_a  out  1  0: PC; 1: rs.
- alu_src_b  out  2  00: rt; 01: constant 4; 10: SignImm; 11: SignImm<<2.
- alu_control  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt.
- pc_src  out  2  00: ALU result; 01: ALUOut; 10: jump target.
- illegal_instr  out  1  high while in TRAP.
- state_dbg  out  STATE_W  current state encoding.

Behaviour:
- Clock and reset: one clock (clk); reset_n is asynchronous and active-low. While reset_n=0: state=FETCH and every output is 0, including state_dbg.
- Output timing: Moore outputs decoded from state. Exceptions: pc_en in BRANCH depends on zero; FETCH/MEM enables are gated by mem_ready.
- State encoding:
  - FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5
  - EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEXEC=9, ADDIWB=10, JUMP=11, TRAP=12
- FETCH:
  - Outputs: iord=0, alu_src_a=0, alu_src_b=01, alu_control=010, pc_src=00.
  - ir_write=pc_en=mem_ready.
  - Next state is DECODE if mem_ready, else stay in FETCH.
- DECODE: alu_src_a=0, alu_src_b=11, add. Next state by opcode:
  - 100011/101011 → MEMADR
  - 000000 → EXECUTE
  - 000100, or 000101 when SUPPORT_BNE=1 → BRANCH
  - 001000 → ADDIEXEC
  - 000010 → JUMP
  - anything else → TRAP
- MEMADR: alu_src_a=1, alu_src_b=10, add. Next state is MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: iord=1; next state is MEMWB when mem_ready, else hold.
- MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1; next state FETCH.
- MEMWRITE: iord=1, mem_write=1 held every cycle until mem_ready; then FETCH.
- EXECUTE: alu_src_a=1, alu_src_b=00, alu_control from funct:
  - 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt.
  - Any other funct: go to TRAP with no register write.
  - Legal funct: next state ALUWB.
- ALUWB: reg_dst=1, mem_to_reg=0, reg_write=1; next state FETCH.
- BRANCH:
  - alu_src_a=1, alu_src_b=00, sub, pc_src=01.
  - take = zero for beq, ~zero for bne.
  - pc_en=take; next state FETCH.
- ADDIEXEC: alu_src_a=1, alu_src_b=10, add; next state ADDIWB.
- ADDIWB: reg_dst=0, mem_to_reg=0, reg_write=1; next state FETCH.
- JUMP: pc_src=10, pc_en=1; next state FETCH.
- TRAP: all enables 0, illegal_instr=1; state holds until reset.
- Latency with mem_ready held high (cycles): R-type 4, lw 5, sw 4, beq/bne 3, addi 4, j 3. Each low mem_ready cycle in FETCH/MEMREAD/MEMWRITE adds one.
- Default for any output not listed in a state: 0.
- Unused state codes 13–15 → FETCH on the next clock.
- Reset asserted mid-instruction: immediate return to FETCH; no partial write enable may be asserted while reset_n=0.
- USE_MEM_READY=0: the design must synthesize with mem_ready unconnected.

Decomposition:
- Shared package mips_pkg holds:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J)
  - funct constants
  - ALU control codes
  - state encodings
  - alu_src_b and pc_src codes
- One sub-module, mips_alu_decoder: combinational funct → alu_control plus a funct_illegal flag. Reused by EXECUTE.
- FSM, output decode and pc_en logic stay in the top.

Test Plan:
- Reset then lw (opcode 100011), mem_ready=1 → states 0,1,2,3,4,0.
  - FETCH: ir_write=1.
  - MEMWB: reg_write=1, mem_to_reg=1.
  - Total 5 cycles.
- add (R-type, funct 100000), then sub (100010) → EXECUTE alu_control=010 then 110; ALUWB reg_dst=1, reg_write=1.
- beq with zero=1 → BRANCH pc_en=1, pc_src=01. beq with zero=0 → pc_en=0. bne with zero=0 → pc_en=1. With SUPPORT_BNE=0, bne → TRAP.
- sw with mem_ready low 3 cycles in MEMWRITE → mem_write=1 for 4 cycles, then FETCH. FETCH with mem_ready low 2 cycles → ir_write=0 and state holds 2 cycles.
- Opcode 111111 → TRAP, illegal_instr=1 and held for 10 cycles; reset_n pulse → FETCH, illegal_instr=0. Same check for R-type with funct 000111.
- reset_n asserted asynchronously mid-MEMWB → outputs 0 within the same cycle; after release, state_dbg=0.
